board_render_ctrl: RTL and testbench

- Sequences the 60x60 tile sprite renderer across the 4x4 2048 board for each VGA frame.
- Decodes the current VGA pixel coordinate into background, grid-gap or tile region. For tile regions it drives tile value and in-tile position to the renderer.
- Delay-matches region and video-enable to the renderer's 2-cycle latency and muxes the final 12-bit colour.
- Owns a frame-synchronous, double-buffered copy of the board so the game logic never causes a mid-frame tear.

---
 rtl/board_pkg.sv | 31 +++
 rtl/board_axis_decode.sv | 56 +++++
 rtl/board_render_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_board_render_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : board_pkg
//  Description : Shared types and constants for the 2048 board render path.
//                Region codes, board geometry and the packed board snapshot
//                type with its tile-index helper.
//  Revision    : 1.0  initial release
// ============================================================================
package board_pkg;

  typedef enum logic [1:0] {
    REG_OUT  = 2'd0,
    REG_GAP  = 2'd1,
    REG_TILE = 2'd2
  } region_e;

  localparam int TILE_SIZE = 60;
  localparam int GAP       = 4;
  localparam int BOARD_DIM = 4;

  // 16 tiles x 4-bit exponent, tile (r,c) at bits [4*(4r+c)+:4]
  typedef logic [63:0] board_t;

  // LSB of tile (row,col) inside board_t: 4*(4*row+col) == {row,col,2'b00}
  function automatic logic [5:0] tile_lsb(input logic [1:0] row,
                                          input logic [1:0] col);
    return {row, col, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/board_axis_decode.sv
`default_nettype none
// ============================================================================
//  Module      : board_axis_decode
//  Description : Combinational decode of one screen axis against the board
//                grid. Reports whether the coordinate lies on the board, in a
//                gap band, which tile column/row it hits and the offset
//                inside that tile.
//  Ports       : coord_i    - 10-bit screen coordinate
//                in_board_o - coordinate lies inside the board extent
//                in_gap_o   - coordinate lies in a gap/border band
//                idx_o      - tile index along this axis (valid in a tile)
//                pos_o      - offset inside the tile (valid in a tile)
//  Revision    : 1.0  initial release
// ============================================================================
module board_axis_decode
  import board_pkg::*;
#(
  parameter int ORIGIN  = 190,
  parameter int TILE_PX = board_pkg::TILE_SIZE,
  parameter int GAP_PX  = board_pkg::GAP
) (
  input  logic [9:0] coord_i,
  output logic       in_board_o,
  output logic       in_gap_o,
  output logic [1:0] idx_o,
  output logic [5:0] pos_o
);

  localparam int EXTENT = BOARD_DIM * TILE_PX + (BOARD_DIM + 1) * GAP_PX;

  logic signed [10:0] rel;
  logic               in_tile;

  assign rel = $signed({1'b0, coord_i}) - $signed(11'(ORIGIN));

  // Tile k spans [GAP + k*(TILE+GAP), GAP + k*(TILE+GAP) + TILE); the bounds
  // are elaboration-time constants so this is a handful of comparators.
  always_comb begin
    in_tile = 1'b0;
    idx_o   = 2'd0;
    pos_o   = 6'd0;
    for (int k = 0; k < BOARD_DIM; k++) begin
      if (rel >= $signed(11'(GAP_PX + k * (TILE_PX + GAP_PX))) &&
          rel <  $signed(11'(GAP_PX + k * (TILE_PX + GAP_PX) + TILE_PX))) begin
        in_tile = 1'b1;
        idx_o   = 2'(k);
        pos_o   = 6'(rel - $signed(11'(GAP_PX + k * (TILE_PX + GAP_PX))));
      end
    end
  end

  assign in_board_o = !rel[10] && (rel < $signed(11'(EXTENT)));
  assign in_gap_o   = in_board_o && !in_tile;

endmodule
`default_nettype wire

// File: rtl/board_render_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : board_render_ctrl
//  Description : Walks the tile sprite renderer across the 4x4 board for each
//                VGA pixel, delay-matches region/video-enable to the
//                renderer latency and muxes the final colour. Holds a
//                frame-synchronous double-buffered board snapshot.
//  Ports       : clk, reset         - pixel clock, sync active-high reset
//                pix_x_i/pix_y_i    - current VGA coordinate
//                video_on_i         - active-video flag for the coordinate
//                frame_start_i      - pulse at start of vertical blank
//                upd_valid_i/upd_ready_o/upd_board_i - snapshot handshake
//                tile_value_o, tile_pos_x_o, tile_pos_y_o - to renderer
//                sprite_pixel_i     - renderer colour output
//                pixel_rgb_o, video_on_out_o - final colour and its enable
//  Revision    : 1.0  initial release
// ============================================================================
module board_render_ctrl
  import board_pkg::*;
#(
  parameter int          BOARD_X0   = 190,
  parameter int          BOARD_Y0   = 110,
  parameter int          TILE_SIZE  = board_pkg::TILE_SIZE,
  parameter int          GAP        = board_pkg::GAP,
  parameter int          RENDER_LAT = 2,
  parameter logic [11:0] BG_COLOR   = 12'hFEE,
  parameter logic [11:0] GRID_COLOR = 12'hBAA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pix_x_i,
  input  logic [9:0]  pix_y_i,
  input  logic        video_on_i,
  input  logic        frame_start_i,
  input  logic        upd_valid_i,
  output logic        upd_ready_o,
  input  board_t      upd_board_i,
  output logic [3:0]  tile_value_o,
  output logic [5:0]  tile_pos_x_o,
  output logic [5:0]  tile_pos_y_o,
  input  logic [11:0] sprite_pixel_i,
  output logic [11:0] pixel_rgb_o,
  output logic        video_on_out_o
);

  // ---------------- board double buffer ----------------
  board_t active_q, active_d;
  board_t pending_q, pending_d;
  logic   pending_valid_q, pending_valid_d;

  assign upd_ready_o = !pending_valid_q;

  // Accept and swap are mutually exclusive (accept needs pending empty, swap
  // needs it full), so a coincident accept/frame_start only fills pending.
  always_comb begin
    active_d        = active_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    if (upd_valid_i && !pending_valid_q) begin
      pending_d       = upd_board_i;
      pending_valid_d = 1'b1;
    end else if (frame_start_i && pending_valid_q) begin
      active_d        = pending_q;
      pending_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
    end else begin
      active_q        <= active_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
    end
  end

  // ---------------- stage 1: coordinate decode ----------------
  logic       x_in, x_gap, y_in, y_gap;
  logic [1:0] x_idx, y_idx;
  logic [5:0] x_pos, y_pos;

  board_axis_decode #(.ORIGIN(BOARD_X0), .TILE_PX(TILE_SIZE), .GAP_PX(GAP)) u_dec_x (
    .coord_i    (pix_x_i),
    .in_board_o (x_in),
    .in_gap_o   (x_gap),
    .idx_o      (x_idx),
    .pos_o      (x_pos)
  );

  board_axis_decode #(.ORIGIN(BOARD_Y0), .TILE_PX(TILE_SIZE), .GAP_PX(GAP)) u_dec_y (
    .coord_i    (pix_y_i),
    .in_board_o (y_in),
    .in_gap_o   (y_gap),
    .idx_o      (y_idx),
    .pos_o      (y_pos)
  );

  region_e    region_d, region_q;
  logic [3:0] tile_value_d, tile_value_q;
  logic [5:0] pos_x_d, pos_x_q, pos_y_d, pos_y_q;
  logic       video_q;

  // Non-tile pixels drive zeros so the renderer address stays in range.
  always_comb begin
    region_d     = REG_OUT;
    tile_value_d = 4'd0;
    pos_x_d      = 6'd0;
    pos_y_d      = 6'd0;
    if (x_in && y_in) begin
      if (x_gap || y_gap) begin
        region_d = REG_GAP;
      end else begin
        region_d     = REG_TILE;
        tile_value_d = active_q[tile_lsb(y_idx, x_idx) +: 4];
        pos_x_d      = x_pos;
        pos_y_d      = y_pos;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      region_q     <= REG_OUT;
      tile_value_q <= 4'd0;
      pos_x_q      <= 6'd0;
      pos_y_q      <= 6'd0;
      video_q      <= 1'b0;
    end else begin
      region_q     <= region_d;
      tile_value_q <= tile_value_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      video_q      <= video_on_i;
    end
  end

  assign tile_value_o = tile_value_q;
  assign tile_pos_x_o = pos_x_q;
  assign tile_pos_y_o = pos_y_q;

  // ---------------- delay line matching renderer latency ----------------
  region_e region_dly_q [RENDER_LAT];
  logic    video_dly_q  [RENDER_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RENDER_LAT; i++) begin
        region_dly_q[i] <= REG_OUT;
        video_dly_q[i]  <= 1'b0;
      end
    end else begin
      region_dly_q[0] <= region_q;
      video_dly_q[0]  <= video_q;
      for (int i = 1; i < RENDER_LAT; i++) begin
        region_dly_q[i] <= region_dly_q[i-1];
        video_dly_q[i]  <= video_dly_q[i-1];
      end
    end
  end

  // ---------------- output colour mux ----------------
  logic [11:0] rgb_d, rgb_q;
  logic        vid_out_q;

  always_comb begin
    rgb_d = 12'h000;
    if (video_dly_q[RENDER_LAT-1]) begin
      case (region_dly_q[RENDER_LAT-1])
        REG_OUT:  rgb_d = BG_COLOR;
        REG_GAP:  rgb_d = GRID_COLOR;
        REG_TILE: rgb_d = sprite_pixel_i;
        default:  rgb_d = 12'h000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q     <= 12'h000;
      vid_out_q <= 1'b0;
    end else begin
      rgb_q     <= rgb_d;
      vid_out_q <= video_dly_q[RENDER_LAT-1];
    end
  end

  assign pixel_rgb_o    = rgb_q;
  assign video_on_out_o = vid_out_q;

endmodule
`default_nettype wire

// File: tb/tb_board_render_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_render_ctrl
//  Description : Directed self-checking bench for board_render_ctrl with a
//                2-cycle renderer model producing {value, x[3:0], y[3:0]}.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_board_render_ctrl;

  localparam int          X0   = 190;
  localparam int          Y0   = 110;
  localparam logic [11:0] BG   = 12'hFEE;
  localparam logic [11:0] GRID = 12'hBAA;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pix_x, pix_y;
  logic        video_on, frame_start, upd_valid, upd_ready;
  logic [63:0] upd_board;
  logic [3:0]  tile_value;
  logic [5:0]  tile_pos_x, tile_pos_y;
  logic [11:0] sprite_pixel, pixel_rgb;
  logic        video_on_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  board_render_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .pix_x_i        (pix_x),
    .pix_y_i        (pix_y),
    .video_on_i     (video_on),
    .frame_start_i  (frame_start),
    .upd_valid_i    (upd_valid),
    .upd_ready_o    (upd_ready),
    .upd_board_i    (upd_board),
    .tile_value_o   (tile_value),
    .tile_pos_x_o   (tile_pos_x),
    .tile_pos_y_o   (tile_pos_y),
    .sprite_pixel_i (sprite_pixel),
    .pixel_rgb_o    (pixel_rgb),
    .video_on_out_o (video_on_out)
  );

  // Renderer model: two register stages, colour built from value and position
  logic [11:0] rend1 = 12'h000;
  logic [11:0] rend2 = 12'h000;
  always @(posedge clk) begin
    rend1 <= {tile_value, tile_pos_x[3:0], tile_pos_y[3:0]};
    rend2 <= rend1;
  end
  assign sprite_pixel = rend2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One pixel for one cycle, then idle; renderer-side outputs checked one
  // cycle later, the colour exactly four cycles after the pixel.
  task automatic probe(input string tag, input int x, input int y, input logic vid,
                       input logic [3:0] tv, input logic [5:0] px, input logic [5:0] py,
                       input logic [11:0] rgb);
    pix_x = 10'(x); pix_y = 10'(y); video_on = vid;
    step();
    check({tag, ".tv"}, 64'(tile_value), 64'(tv));
    check({tag, ".px"}, 64'(tile_pos_x), 64'(px));
    check({tag, ".py"}, 64'(tile_pos_y), 64'(py));
    pix_x = 10'd0; pix_y = 10'd0; video_on = 1'b0;
    step(); step();
    check({tag, ".early"}, 64'(pixel_rgb), 64'h0);
    step();
    check({tag, ".rgb"}, 64'(pixel_rgb), 64'(rgb));
    check({tag, ".vid"}, 64'(video_on_out), 64'(vid));
  endtask

  task automatic offer(input logic [63:0] b);
    upd_valid = 1'b1; upd_board = b;
    step();
    upd_valid = 1'b0;
  endtask

  task automatic fstart();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pix_x = '0; pix_y = '0; video_on = 1'b0;
    frame_start = 1'b0; upd_valid = 1'b0; upd_board = '0;
    step(); step(); step();
    check("rst.ready", 64'(upd_ready), 64'h1);
    check("rst.rgb",   64'(pixel_rgb), 64'h0);
    check("rst.vid",   64'(video_on_out), 64'h0);
    check("rst.tv",    64'(tile_value), 64'h0);
    reset = 1'b0;
    step();

    // Board: tile(0,0)=1, tile(1,2)=5, tile(3,3)=12
    offer(64'hC000_0000_0500_0001);
    check("acc.ready0", 64'(upd_ready), 64'h0);
    fstart();
    check("swap.ready1", 64'(upd_ready), 64'h1);

    probe("t00",     X0+4,   Y0+4,   1'b1, 4'd1,  6'd0,  6'd0,  12'h100);
    probe("lborder", X0+3,   Y0+30,  1'b1, 4'd0,  6'd0,  6'd0,  GRID);
    probe("colgap",  X0+64,  Y0+10,  1'b1, 4'd0,  6'd0,  6'd0,  GRID);
    probe("origin",  0,      0,      1'b1, 4'd0,  6'd0,  6'd0,  BG);
    probe("vidoff",  X0+4,   Y0+4,   1'b0, 4'd1,  6'd0,  6'd0,  12'h000);
    probe("rbcorn",  X0+259, Y0+259, 1'b1, 4'd0,  6'd0,  6'd0,  GRID);
    probe("t33",     X0+255, Y0+255, 1'b1, 4'd12, 6'd59, 6'd59, 12'hCBB);
    probe("xout",    X0+260, Y0+100, 1'b1, 4'd0,  6'd0,  6'd0,  BG);
    probe("t12",     X0+142, Y0+88,  1'b1, 4'd5,  6'd10, 6'd20, 12'h5A4);
    probe("yabove",  X0+4,   Y0-1,   1'b1, 4'd0,  6'd0,  6'd0,  BG);

    // Second snapshot held off while pending is full
    offer(64'h2);
    check("hs.ready0", 64'(upd_ready), 64'h0);
    upd_valid = 1'b1; upd_board = 64'h3;
    step(); step();
    upd_valid = 1'b0;
    check("hs.held", 64'(upd_ready), 64'h0);
    probe("hs.old", X0+4, Y0+4, 1'b1, 4'd1, 6'd0, 6'd0, 12'h100);
    fstart();
    check("hs.ready1", 64'(upd_ready), 64'h1);
    probe("hs.new", X0+4, Y0+4, 1'b1, 4'd2, 6'd0, 6'd0, 12'h200);

    // Accept coincident with frame_start: lands in pending only
    upd_valid = 1'b1; upd_board = 64'h4; frame_start = 1'b1;
    step();
    upd_valid = 1'b0; frame_start = 1'b0;
    check("co.ready0", 64'(upd_ready), 64'h0);
    probe("co.same", X0+4, Y0+4, 1'b1, 4'd2, 6'd0, 6'd0, 12'h200);
    fstart();
    probe("co.next", X0+4, Y0+4, 1'b1, 4'd4, 6'd0, 6'd0, 12'h400);

    // Reset mid-scan with a full pipeline and a pending snapshot
    offer(64'h7);
    pix_x = 10'(X0+4); pix_y = 10'(Y0+4); video_on = 1'b1;
    step(); step(); step(); step();
    check("mr.pre", 64'(pixel_rgb), 64'h400);
    reset = 1'b1;
    step();
    check("mr.rgb", 64'(pixel_rgb), 64'h0);
    check("mr.vid", 64'(video_on_out), 64'h0);
    check("mr.tv",  64'(tile_value), 64'h0);
    reset = 1'b0;
    step();
    check("mr.ready", 64'(upd_ready), 64'h1);
    check("mr.active", 64'(tile_value), 64'h0);
    step(); step();
    check("mr.flush.rgb", 64'(pixel_rgb), 64'h0);
    check("mr.flush.vid", 64'(video_on_out), 64'h0);
    step();
    check("mr.after.vid", 64'(video_on_out), 64'h1);
    check("mr.after.rgb", 64'(pixel_rgb), 64'h0);
    video_on = 1'b0;
    fstart();
    probe("mr.nopend", X0+4, Y0+4, 1'b1, 4'd0, 6'd0, 6'd0, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
